// File: rtl/kgp_if_pkg.sv
// Shared types and constants for the KGP_RISC instruction-fetch stage.
package kgp_if_pkg;

    localparam int PC_W     = 8;
    localparam int INSTR_W  = 32;
    localparam int FQ_DEPTH = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        FETCH,
        WAIT_ACK,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    npc;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// Small synchronous FIFO of fetched {instr, npc} entries with flush and a combinational head.
module fetch_queue
    import kgp_if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  fq_entry_t        push_data_i,
    input  logic             pop_i,
    output fq_entry_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // A pop frees a slot in the same cycle, so push into a full queue is legal then.
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// KGP_RISC instruction-fetch stage: PC, imem req/ack handshake, redirect/stall handling,
// and presentation of the fetch-queue head to IF/ID.
module if_fetch_stage
    import kgp_if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic               stall_i,
    output logic [INSTR_W-1:0] instr_out_o,
    output logic [PC_W-1:0]    npc_out_o,
    output logic               instr_valid_o
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic             run_q;
    logic             req, push, pop, has_room, present;
    logic [PC_W-1:0]  addr;
    logic [CNT_W-1:0] count;
    fq_entry_t        head, push_entry;

    assign pop        = (count != '0) && !stall_i && !redirect_i;
    assign has_room   = (count < CNT_W'(FQ_DEPTH)) || pop;
    assign push_entry = '{instr: imem_rdata_i, npc: addr + PC_W'(1)};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        addr       = addr_q;
        req        = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            FETCH: begin
                addr = fetch_pc_q;
                // run_q keeps the request low until the first edge after reset release.
                if (run_q && has_room && !redirect_i) begin
                    req = 1'b1;
                    if (imem_ack_i) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_W'(1);
                    end else begin
                        state_d = WAIT_ACK;
                        addr_d  = fetch_pc_q;
                    end
                end
            end
            WAIT_ACK: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // Old-path data acked now is dropped; an unacked request must still be drained.
        if (redirect_i) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc_i;
            state_d    = (req && !imem_ack_i) ? DISCARD : FETCH;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            run_q      <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign present = (count != '0) && !redirect_i;

    always_comb begin
        instr_out_o   = NOP_INSTR;
        npc_out_o     = '0;
        instr_valid_o = present;
        if (present) begin
            instr_out_o = head.instr;
            npc_out_o   = head.npc;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = addr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a latency-programmable memory model feeds the DUT,
// expected {instr, npc} entries are queued on ack and compared when IF/ID consumes them.
module tb_if_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, ack, redirect, stall, valid;
    logic [7:0]  addr, redirect_pc, npc;
    logic [31:0] rdata, instr;

    logic        w_req, w_valid;
    logic [7:0]  w_addr, w_npc;
    logic [31:0] w_rdata, w_instr;

    int          n_total = 0;
    int          n_bad = 0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    int          redir_pops = 0;
    exp_t        sb[$];
    logic [7:0]  wa[$];
    logic [7:0]  wn[$];
    logic [7:0]  exp_fetch = 8'h00;
    logic [7:0]  prev_addr = 8'h00;
    logic [7:0]  redir_tgt = 8'h00;
    bit          discard_pend = 1'b0;
    bit          prev_pending = 1'b0;
    bit          log_wrap = 1'b0;
    bit          redir_chk = 1'b0;

    logic        obs_req, obs_ack, obs_valid, obs_hold;
    logic [7:0]  obs_addr, obs_npc;
    logic [31:0] obs_instr;

    function automatic logic [31:0] enc(input logic [7:0] a);
        return {16'hC0DE, a, ~a};
    endfunction

    always #5 clk = ~clk;

    assign w_rdata = enc(w_addr);

    if_fetch_stage #(.RESET_PC(8'h00)) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .instr_out_o   (instr),
        .npc_out_o     (npc),
        .instr_valid_o (valid)
    );

    if_fetch_stage #(.RESET_PC(8'hFE)) u_wrap (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (w_req),
        .imem_addr_o   (w_addr),
        .imem_ack_i    (w_req),
        .imem_rdata_i  (w_rdata),
        .redirect_i    (1'b0),
        .redirect_pc_i (8'h00),
        .stall_i       (1'b0),
        .instr_out_o   (w_instr),
        .npc_out_o     (w_npc),
        .instr_valid_o (w_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reset_check();
        check_eq("rst_req", req, 1'b0);
        check_eq("rst_addr", addr, 8'h00);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_npc", npc, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_wrap_req", w_req, 1'b0);
        check_eq("rst_wrap_addr", w_addr, 8'hFE);
    endtask

    task automatic release_reset();
        rst_n        = 1'b1;
        sb.delete();
        exp_fetch    = 8'h00;
        discard_pend = 1'b0;
        wait_cnt     = 0;
        prev_pending = 1'b0;
        redir_chk    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ack = 1'b0; rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        reset_check();
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    // One clock cycle: drive controls, answer the memory, then score the settled outputs.
    task automatic step(input logic st, input logic rd, input logic [7:0] rpc);
        @(negedge clk);
        stall = st; redirect = rd; redirect_pc = rpc;
        #1;
        if (req) begin
            if (wait_cnt >= mem_lat) begin
                ack = 1'b1; rdata = enc(addr); wait_cnt = 0;
            end else begin
                ack = 1'b0; rdata = '0; wait_cnt++;
            end
        end else begin
            ack = 1'b0; rdata = '0; wait_cnt = 0;
        end
        #1;
        obs_hold = prev_pending; obs_req = req; obs_addr = addr; obs_ack = ack;
        obs_valid = valid; obs_instr = instr; obs_npc = npc;

        if (prev_pending) begin
            check_eq("req_hold", req, 1'b1);
            check_eq("addr_hold", addr, prev_addr);
        end

        if (rd) begin
            check_eq("redir_valid", valid, 1'b0);
            check_eq("redir_instr", instr, 32'h0);
            check_eq("redir_npc_bubble", npc, 8'h00);
            if (req && !ack) discard_pend = 1'b1;
            else if (req && ack) discard_pend = 1'b0;
            sb.delete();
            exp_fetch = rpc;
            redir_tgt = rpc;
            redir_chk = 1'b1;
        end else begin
            if (valid) begin
                check_eq("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    check_eq("instr", instr, sb[0].instr);
                    check_eq("npc", npc, sb[0].npc);
                    if (!st) begin
                        if (redir_chk) begin
                            check_eq("redir_first_npc", npc, redir_tgt + 8'd1);
                            redir_chk = 1'b0;
                            redir_pops++;
                        end
                        $display("pop npc=%02h instr=%08h", npc, instr);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check_eq("bubble_instr", instr, 32'h0);
                check_eq("bubble_npc", npc, 8'h00);
            end
            if (ack) begin
                if (discard_pend) begin
                    discard_pend = 1'b0;
                end else begin
                    check_eq("fetch_addr", addr, exp_fetch);
                    sb.push_back('{instr: enc(addr), npc: addr + 8'd1});
                    exp_fetch = exp_fetch + 8'd1;
                end
            end
        end

        if (log_wrap) begin
            if (w_req) wa.push_back(w_addr);
            if (w_valid) wn.push_back(w_npc);
        end
        prev_pending = req && !ack;
        prev_addr    = addr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bit          found;
        ack = 1'b0; rdata = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Zero-wait memory: first request right after release, valid one cycle later, 1 IPC.
        mem_lat = 0;
        do_reset();
        log_wrap = 1'b1;
        step(0, 0, 0);
        check_eq("first_req", obs_req, 1'b1);
        check_eq("first_valid_early", obs_valid, 1'b0);
        step(0, 0, 0);
        check_eq("first_valid", obs_valid, 1'b1);
        check_eq("first_npc", obs_npc, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            check_eq("throughput", obs_valid, 1'b1);
        end
        log_wrap = 1'b0;
        check_eq("wrap_addr_cnt", wa.size() >= 3, 1'b1);
        check_eq("wrap_npc_cnt", wn.size() >= 3, 1'b1);
        if (wa.size() >= 3 && wn.size() >= 3) begin
            check_eq("wrap_addr0", wa[0], 8'hFE);
            check_eq("wrap_addr1", wa[1], 8'hFF);
            check_eq("wrap_addr2", wa[2], 8'h00);
            check_eq("wrap_npc0", wn[0], 8'hFF);
            check_eq("wrap_npc1", wn[1], 8'h00);
            check_eq("wrap_npc2", wn[2], 8'h01);
        end

        // Three wait cycles per access.
        mem_lat = 3;
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // Stall with zero-wait memory: queue fills, request drops, resumes cleanly.
        mem_lat = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 0);
        held = obs_instr;
        check_eq("stall_valid", obs_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check_eq("stall_hold", obs_instr, held);
            check_eq("full_noreq", obs_req, 1'b0);
        end
        step(0, 0, 0);
        check_eq("resume_req", obs_req, 1'b1);
        check_eq("resume_instr", obs_instr, held);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Redirect to 0x40 while a request to 0x05 is outstanding.
        do_reset();
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, 0, 0);
            if (obs_req && obs_addr == 8'h05 && !obs_ack) found = 1'b1;
        end
        check_eq("find_req05", found, 1'b1);
        redir_pops = 0;
        step(0, 1, 8'h40);
        check_eq("discard_req", obs_req, 1'b1);
        check_eq("discard_addr", obs_addr, 8'h05);
        for (int i = 0; i < 40 && redir_pops == 0; i++) step(0, 0, 0);
        check_eq("redir_resumed", redir_pops > 0, 1'b1);

        // Asynchronous reset while waiting for an ack.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0);
            if (obs_hold && !obs_ack) found = 1'b1;
        end
        check_eq("find_wait_ack", found, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0; ack = 1'b0; rdata = '0;
        #1;
        reset_check();
        repeat (2) @(negedge clk);
        release_reset();
        mem_lat = 0;
        step(0, 0, 0);
        check_eq("restart_req", obs_req, 1'b1);
        check_eq("restart_addr", obs_addr, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
